// File: rtl/tri_proj_unit.sv
// ---------------------------------------------------------------------------
// tri_proj_unit
//   Perspective projection of one homogeneous vertex: returns x/z and y/z as
//   IEEE-754 single floats (focal length 1.0). Two restoring mantissa
//   dividers share the z divisor and run in lockstep, one quotient bit per
//   cycle, so every vertex takes a fixed 26 edges from accept to result.
//
// Ports
//   clk_in       system clock, rising edge
//   rst_in       asynchronous active-low reset
//   coor_in[3:0] vertex {x, y, z, w}; w is ignored
//   valid_in     accept strobe, honoured only while idle
//   coor_out[1:0] {x/z, y/z}, held between results
//   valid_out    one-cycle pulse when coor_out is updated
// ---------------------------------------------------------------------------
module tri_proj_unit (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] coor_in [3:0],
  input  logic        valid_in,
  output logic [31:0] coor_out [1:0],
  output logic        valid_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic [7:0]  ex_q, ex_d, ey_q, ey_d, ez_q, ez_d;
  logic [24:0] rx_q, rx_d, ry_q, ry_d;
  logic [23:0] mz_q, mz_d;
  logic [24:0] qx_q, qx_d, qy_q, qy_d;
  logic [31:0] ox_q, ox_d, oy_q, oy_d;
  logic        vo_q, vo_d;

  // w carries no information for this stage
  logic unused_w;
  assign unused_w = ^coor_in[0];

  // Mantissa with hidden bit; zero/denormal operands unpack to zero.
  function automatic logic [23:0] unpack_man(input logic [31:0] f);
    unpack_man = (f[30:23] == 8'd0) ? 24'd0 : {1'b1, f[22:0]};
  endfunction

  // Normalize one quotient and apply all special-value overrides.
  // Truncation: discarded quotient bits are simply dropped.
  function automatic logic [31:0] pack_result(
    input logic        s_n,
    input logic [7:0]  e_n,
    input logic        s_z,
    input logic [7:0]  e_z,
    input logic        any_nan,
    input logic [24:0] q
  );
    logic              sgn;
    logic signed [9:0] e;
    logic [22:0]       man;
    sgn = s_n ^ s_z;
    if (q[24]) begin
      man = q[23:1];
      e   = $signed({2'b00, e_n}) - $signed({2'b00, e_z}) + 10'sd127;
    end else begin
      man = q[22:0];
      e   = $signed({2'b00, e_n}) - $signed({2'b00, e_z}) + 10'sd126;
    end
    if (any_nan)                            pack_result = 32'h7fc00000;
    else if (e_z == 8'd0 && e_n == 8'd0)    pack_result = 32'h7fc00000;
    else if (e_z == 8'd0)                   pack_result = {sgn, 8'hff, 23'd0};
    else if (e_n == 8'd0)                   pack_result = {sgn, 31'd0};
    else if (e >= 10'sd255)                 pack_result = {sgn, 8'hff, 23'd0};
    else if (e <= 10'sd0)                   pack_result = {sgn, 31'd0};
    else                                    pack_result = {sgn, e[7:0], man};
  endfunction

  logic        ge_x, ge_y, any_nan;
  logic [24:0] sub_x, sub_y;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sx_d = sx_q; sy_d = sy_q; sz_d = sz_q;
    ex_d = ex_q; ey_d = ey_q; ez_d = ez_q;
    rx_d = rx_q; ry_d = ry_q; mz_d = mz_q;
    qx_d = qx_q; qy_d = qy_q;
    ox_d = ox_q; oy_d = oy_q;
    vo_d = 1'b0;

    ge_x  = rx_q >= {1'b0, mz_q};
    ge_y  = ry_q >= {1'b0, mz_q};
    sub_x = rx_q - {1'b0, mz_q};
    sub_y = ry_q - {1'b0, mz_q};
    any_nan = (ex_q == 8'hff) || (ey_q == 8'hff) || (ez_q == 8'hff);

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          sx_d = coor_in[3][31]; ex_d = coor_in[3][30:23];
          sy_d = coor_in[2][31]; ey_d = coor_in[2][30:23];
          sz_d = coor_in[1][31]; ez_d = coor_in[1][30:23];
          rx_d = {1'b0, unpack_man(coor_in[3])};
          ry_d = {1'b0, unpack_man(coor_in[2])};
          mz_d = unpack_man(coor_in[1]);
          qx_d = 25'd0;
          qy_d = 25'd0;
          cnt_d   = 5'd0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Remainder stays below mz < 2^24 after each step, so the left
        // shift never loses a significant bit.
        rx_d = ge_x ? {sub_x[23:0], 1'b0} : {rx_q[23:0], 1'b0};
        ry_d = ge_y ? {sub_y[23:0], 1'b0} : {ry_q[23:0], 1'b0};
        qx_d = {qx_q[23:0], ge_x};
        qy_d = {qy_q[23:0], ge_y};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = S_NORM;
      end
      S_NORM: begin
        ox_d = pack_result(sx_q, ex_q, sz_q, ez_q, any_nan, qx_q);
        oy_d = pack_result(sy_q, ey_q, sz_q, ez_q, any_nan, qy_q);
        vo_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      sx_q <= 1'b0; sy_q <= 1'b0; sz_q <= 1'b0;
      ex_q <= 8'd0; ey_q <= 8'd0; ez_q <= 8'd0;
      rx_q <= 25'd0; ry_q <= 25'd0; mz_q <= 24'd0;
      qx_q <= 25'd0; qy_q <= 25'd0;
      ox_q <= 32'd0; oy_q <= 32'd0;
      vo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sx_q <= sx_d; sy_q <= sy_d; sz_q <= sz_d;
      ex_q <= ex_d; ey_q <= ey_d; ez_q <= ez_d;
      rx_q <= rx_d; ry_q <= ry_d; mz_q <= mz_d;
      qx_q <= qx_d; qy_q <= qy_d;
      ox_q <= ox_d; oy_q <= oy_d;
      vo_q <= vo_d;
    end
  end

  assign coor_out[1] = ox_q;
  assign coor_out[0] = oy_q;
  assign valid_out   = vo_q;

endmodule

// File: tb/tb_tri_proj_unit.sv
// ---------------------------------------------------------------------------
// tb_tri_proj_unit
//   Directed self-checking bench for tri_proj_unit. Expected values are
//   hand-computed IEEE-754 results of x/z and y/z with truncation.
// ---------------------------------------------------------------------------
module tb_tri_proj_unit;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] coor_in [3:0];
  logic        valid_in;
  logic [31:0] coor_out [1:0];
  logic        valid_out;

  int vectors;
  int miscompares;

  tri_proj_unit dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .coor_in  (coor_in),
    .valid_in (valid_in),
    .coor_out (coor_out),
    .valid_out(valid_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one vertex for a single clock edge; returns at the negedge after it.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    coor_in[3] = x; coor_in[2] = y; coor_in[1] = z; coor_in[0] = 32'h3f800000;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // Count edges until valid_out is seen, bounded to 40.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (valid_out !== 1'b1 && n < 40);
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] z, input logic [31:0] ex, input logic [31:0] ey);
    int n;
    @(negedge clk_in);
    issue(x, y, z);
    wait_valid(n);
    check({tag, " latency"}, n, 26);
    check({tag, " x/z"}, coor_out[1], ex);
    check({tag, " y/z"}, coor_out[0], ey);
    @(negedge clk_in);
    check({tag, " single pulse"}, {31'd0, valid_out}, 32'd0);
  endtask

  initial begin
    int n, pulses, changes;
    vectors = 0;
    miscompares = 0;
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) coor_in[i] = 32'd0;

    // Asynchronous reset with no clock edge in between
    rst_in = 1'b1;
    #2 rst_in = 1'b0;
    #1;
    check("reset x", coor_out[1], 32'h0);
    check("reset y", coor_out[0], 32'h0);
    check("reset valid", {31'd0, valid_out}, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    run("equal",   32'h40c00000, 32'h40c00000, 32'h40c00000, 32'h3f800000, 32'h3f800000);
    run("mixed",   32'h40400000, 32'hc0c00000, 32'h40000000, 32'h3fc00000, 32'hc0400000);
    run("third",   32'h3f800000, 32'h00000000, 32'h40400000, 32'h3eaaaaaa, 32'h00000000);
    run("zdiv0",   32'h3f800000, 32'hbf800000, 32'h00000000, 32'h7f800000, 32'hff800000);
    run("zero0",   32'h00000000, 32'h3f800000, 32'h00000000, 32'h7fc00000, 32'h7f800000);
    run("inf_in",  32'h7f800000, 32'h3f800000, 32'h40000000, 32'h7fc00000, 32'h7fc00000);
    run("ovf",     32'h7f000000, 32'h00000000, 32'h3f000000, 32'h7f800000, 32'h00000000);
    run("unf",     32'h00800000, 32'h80800000, 32'h40800000, 32'h00000000, 32'h80000000);

    // Busy drop: second strobe 5 edges after the first is ignored
    @(negedge clk_in);
    issue(32'h40400000, 32'hc0c00000, 32'h40000000);
    repeat (4) @(negedge clk_in);
    issue(32'h40c00000, 32'h40c00000, 32'h40c00000);
    wait_valid(n);
    check("busy latency", n, 21);
    check("busy x/z", coor_out[1], 32'h3fc00000);
    check("busy y/z", coor_out[0], 32'hc0400000);
    pulses = 0;
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (valid_out === 1'b1) pulses++;
      if (coor_out[1] !== 32'h3fc00000 || coor_out[0] !== 32'hc0400000) changes++;
    end
    check("busy extra pulses", pulses, 0);
    check("busy hold", changes, 0);

    // Reset during DIV aborts the vertex
    issue(32'h40c00000, 32'h40c00000, 32'h40c00000);
    repeat (9) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    check("abort x", coor_out[1], 32'h0);
    check("abort y", coor_out[0], 32'h0);
    check("abort valid", {31'd0, valid_out}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (valid_out === 1'b1) pulses++;
    end
    check("abort pulses", pulses, 0);
    run("post_abort", 32'h40400000, 32'hc0c00000, 32'h40000000, 32'h3fc00000, 32'hc0400000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tri_proj_unit.md
# tri_proj_unit

Perspective-projection stage of the 3D pipeline. It takes one homogeneous vertex (x, y, z, w) as IEEE-754 single-precision floats and produces the projected 2D screen coordinates x/z and y/z with focal length 1.0. It sits between the vertex transform stage and the rasterizer. It processes one vertex at a time using an iterative mantissa divider.

## Interface
- No parameters.
- Clocking and reset: one clock, `clk_in`. Reset `rst_in` is asynchronous and active-low.
- `clk_in`  in  1  system clock; all state updates on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `coor_in`  in  32 x [3:0] unpacked  vertex, IEEE-754 single:
  - [3] = x, [2] = y, [1] = z, [0] = w.
  - w is nominally 1.0 (0x3f800000) and is ignored.
- `valid_in`  in  1  one-cycle strobe; `coor_in` is sampled when this is high and the block is IDLE.
- `coor_out`  out  32 x [1:0] unpacked  result, IEEE-754 single: [1] = x/z, [0] = y/z.
- `valid_out`  out  1  one-cycle pulse; `coor_out` is valid from this cycle onward.

## Operation
- FSM states are IDLE, DIV and NORM.
- **IDLE**
  - On `valid_in` = 1: register x, y, z.
  - Unpack each operand into sign, 8-bit exponent and 24-bit mantissa with the hidden 1.
  - Set the 5-bit iteration counter to 0 and go to DIV.
  - `valid_in` while in DIV or NORM is dropped. There is no queue and no stall.
- **DIV**
  - Two restoring dividers run in lockstep: mx/mz and my/mz.
  - Each produces 25 quotient bits, MSB first, one bit per cycle.
  - After 25 cycles, go to NORM.
- **NORM**, for each of x and y:
  - sign = s_num XOR s_z.
  - If quotient bit 24 is 1: mantissa = q[23:1], exp = e_num − e_z + 127.
  - Otherwise: mantissa = q[22:0], exp = e_num − e_z + 126.
  - Exponent arithmetic is signed, 10-bit.
  - Rounding is truncation (round toward zero).
  - Register `coor_out`, pulse `valid_out`, return to IDLE.
- **Special cases** (input exponent 0 means zero; denormals are flushed to zero):
  - Any of x, y, z with exponent 255 (Inf or NaN): both outputs are 0x7fc00000.
  - z is zero and numerator is zero: 0x7fc00000.
  - z is zero and numerator is nonzero: signed infinity (exp 255, mantissa 0).
  - Numerator is zero and z is nonzero: signed zero.
  - Computed exp ≥ 255: signed infinity.
  - Computed exp ≤ 0: signed zero.
- Special cases still take the full fixed latency.
- `coor_out` holds its value between results. It changes only in the NORM cycle.

## Timing
- Reset (asynchronous, `rst_in` low):
  - FSM goes to IDLE.
  - `valid_out` = 0; `coor_out[1]` = `coor_out[0]` = 32'h0.
  - Counter and datapath registers are cleared.
- Deassertion of `rst_in` is assumed synchronous to `clk_in` by the top level.
- Latency:
  - `valid_in` is sampled at rising edge k.
  - DIV occupies edges k+1 .. k+25.
  - NORM result is registered at edge k+26; `valid_out` is high for exactly the cycle following edge k+26.
- Throughput: one vertex per 27 cycles. The earliest next accepted `valid_in` is at edge k+27, the cycle `valid_out` is high.
- Reset asserted during DIV or NORM aborts the computation. No `valid_out` is produced for the aborted vertex.
- `valid_in` held high continuously: a new vertex is accepted every 27 cycles (at each IDLE cycle).

## Test plan
- **Reset**: hold `rst_in` low mid-cycle with no clock edge -> `coor_out` = {0, 0} and `valid_out` = 0 immediately.
- **Equal operands**: x = y = z = 6.0 (0x40c00000), w = 1.0, `valid_in` pulse -> exactly one `valid_out` pulse 26 edges later, `coor_out[1]` = `coor_out[0]` = 0x3f800000.
- **Mixed signs and normalization**: x = 3.0 (0x40400000), y = −6.0 (0xc0c00000), z = 2.0 (0x40000000) -> `coor_out[1]` = 0x3fc00000 (1.5), `coor_out[0]` = 0xc0400000 (−3.0).
- **Truncation and special values**:
  - x = 1.0, y = 0.0, z = 3.0 (0x40400000) -> `coor_out[1]` = 0x3eaaaaaa (truncated 1/3), `coor_out[0]` = 0x00000000.
  - z = 0.0 with x = 1.0, y = −1.0 -> 0x7f800000 and 0xff800000.
- **Busy drop**: second `valid_in` pulse 5 cycles after the first -> only the first vertex's result appears, a single `valid_out` pulse. `coor_out` then holds that value for 100 cycles.
- **Reset mid-operation**: `rst_in` low for one cycle at edge k+10 -> no `valid_out`, outputs 0. A fresh vertex issued afterwards completes normally after 26 edges.
